edge_detect_multi: RTL

EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

---
 rtl/edge_detect_multi.sv | 131 +++++++++++++
 1 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: synchronizes asynchronous inputs, filters out
// short glitches, reports accepted edges as pulses and keeps a sticky flag and
// a saturating event counter for each channel.
module edge_detect_multi #(
   parameter int              N_CH        = 4,
   parameter int              SYNC_STAGES = 2,
   parameter int              FILTER_LEN  = 4,
   parameter int              CNT_W       = 8,
   parameter logic [N_CH-1:0] INIT_LEVEL  = '1
) (
   input  logic                   clk50m,
   input  logic                   rst,
   input  logic [N_CH-1:0]        in,
   input  logic [2*N_CH-1:0]      mode,
   input  logic [N_CH-1:0]        cnt_clr,
   input  logic [N_CH-1:0]        flag_clr,
   output logic [N_CH-1:0]        level,
   output logic [N_CH-1:0]        risingedge,
   output logic [N_CH-1:0]        fallingedge,
   output logic [N_CH-1:0]        evt,
   output logic [N_CH-1:0]        evt_flag,
   output logic [N_CH*CNT_W-1:0]  evt_cnt,
   output logic                   any_evt
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0] STAB_LAST = FW'(FILTER_LEN - 1);

   // Next-cycle event of every channel, gathered so any_evt can be registered
   // in the same cycle as the individual evt bits.
   logic [N_CH-1:0] evt_next_vec;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] chain;
      logic [FW-1:0]          stab;
      logic                   level_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   evt_q;
      logic                   flag_q;
      logic [CNT_W-1:0]       cnt_q;
      logic                   synced;
      logic                   accept;
      logic                   rise_next;
      logic                   fall_next;
      logic [1:0]             ch_mode;

      assign synced    = chain[SYNC_STAGES-1];
      // A level change is accepted once the new value has been stable for
      // FILTER_LEN consecutive samples (this edge included).
      assign accept    = (synced != level_q) && (stab == STAB_LAST);
      assign rise_next = accept & synced;
      assign fall_next = accept & ~synced;
      assign ch_mode   = mode[2*i +: 2];

      assign evt_next_vec[i] = (rise_next & ch_mode[0]) | (fall_next & ch_mode[1]);

      // Synchronizer chain; reset preloads the idle level so release cannot
      // look like an edge.
      always_ff @(posedge clk50m) begin
         if (rst) begin
            chain <= {SYNC_STAGES{INIT_LEVEL[i]}};
         end else begin
            chain <= {chain[SYNC_STAGES-2:0], in[i]};
         end
      end

      // Stability filter, accepted level and registered edge/event pulses.
      always_ff @(posedge clk50m) begin
         if (rst) begin
            stab    <= '0;
            level_q <= INIT_LEVEL[i];
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            evt_q   <= 1'b0;
         end else begin
            rise_q <= rise_next;
            fall_q <= fall_next;
            evt_q  <= evt_next_vec[i];
            if (synced == level_q) begin
               stab <= '0;
            end else if (accept) begin
               stab    <= '0;
               level_q <= synced;
            end else begin
               stab <= stab + FW'(1);
            end
         end
      end

      // Saturating event counter; a clear coinciding with an event leaves one
      // counted event.
      always_ff @(posedge clk50m) begin
         if (rst) begin
            cnt_q <= '0;
         end else if (cnt_clr[i]) begin
            cnt_q <= evt_q ? CNT_W'(1) : '0;
         end else if (evt_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      // Sticky flag; setting wins over a simultaneous clear.
      always_ff @(posedge clk50m) begin
         if (rst) begin
            flag_q <= 1'b0;
         end else if (evt_q) begin
            flag_q <= 1'b1;
         end else if (flag_clr[i]) begin
            flag_q <= 1'b0;
         end
      end

      assign level[i]                   = level_q;
      assign risingedge[i]              = rise_q;
      assign fallingedge[i]             = fall_q;
      assign evt[i]                     = evt_q;
      assign evt_flag[i]                = flag_q;
      assign evt_cnt[i*CNT_W +: CNT_W]  = cnt_q;
   end

   // Summary event pulse, aligned with the per-channel evt outputs.
   always_ff @(posedge clk50m) begin
      if (rst) begin
         any_evt <= 1'b0;
      end else begin
         any_evt <= |evt_next_vec;
      end
   end

endmodule
